// File: rtl/ascon_seq_pkg.sv
// Shared definitions for the Ascon command sequencer: operation codes,
// FSM state encoding and the default block-counter width.
package ascon_seq_pkg;

   localparam int LEN_W_DEF = 32;

   typedef enum logic [1:0] {
      OP_ENC     = 2'd0,
      OP_DEC     = 2'd1,
      OP_HASH    = 2'd2,
      OP_ILLEGAL = 2'd3
   } seq_op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INIT     = 3'd1,
      ST_AD_WAIT  = 3'd2,
      ST_AD_RUN   = 3'd3,
      ST_TXT_WAIT = 3'd4,
      ST_TXT_RUN  = 3'd5,
      ST_FINAL    = 3'd6,
      ST_DONE     = 3'd7
   } seq_state_e;

endpackage

// File: rtl/ascon_seq_out_buf.sv
// Single-entry 128-bit output holding register with a valid/ready drain side.
// A flush discards a pending beat; data is held stable while valid is high.
module ascon_seq_out_buf (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         flush,
   input  logic [127:0] load_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [127:0] out_data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ascon_core_seq.sv
// Command-level sequencer driving the single-permutation Ascon core phases.
// Optional macro ASCON_SEQ_TAG_CHECK_EN adds exp_tag input and tag_fail output.
module ascon_core_seq
   import ascon_seq_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [1:0]       cmd_sel_type,
   input  logic [LEN_W-1:0] cmd_ad_blocks,
   input  logic [LEN_W-1:0] cmd_txt_blocks,
`ifdef ASCON_SEQ_TAG_CHECK_EN
   input  logic [127:0]     exp_tag,
   output logic             tag_fail,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             done,
   output logic [127:0]     tag_out,
   output logic             err_out,
   output logic             core_en_init,
   output logic             core_en_ad,
   output logic             core_en_txt,
   output logic             core_en_hash,
   output logic             core_en_final,
   output logic [1:0]       core_sel_type,
   output logic             core_mode_dec,
   output logic [LEN_W-1:0] core_data_length,
   output logic [LEN_W-1:0] core_data_position,
   output logic [127:0]     core_data_in,
   input  logic [127:0]     core_data_out,
   input  logic [127:0]     core_tag,
   input  logic             core_err
);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   seq_state_e       state, state_nxt;
   seq_op_e          op_q;
   logic [LEN_W-1:0] ad_n_q, txt_n_q, idx_q;
   logic             run_cnt_q, illegal_q;
   logic             any_en, err_hit, accept, in_hs, run_last, last_blk, ob_load;
   logic [127:0]     ob_load_data;

   assign any_en   = core_en_init | core_en_ad | core_en_txt | core_en_hash | core_en_final;
   assign err_hit  = any_en & core_err;
   assign accept   = cmd_valid & cmd_ready;
   assign in_ready = ((state == ST_AD_WAIT) || (state == ST_TXT_WAIT)) && !(out_valid && !out_ready);
   assign in_hs    = in_valid & in_ready;
   assign run_last = run_cnt_q && ((state == ST_AD_RUN) || (state == ST_TXT_RUN));
   assign last_blk = (state == ST_AD_RUN) ? (idx_q == ad_n_q) : (idx_q == txt_n_q);
   assign done     = ((state == ST_DONE) && !out_valid) || illegal_q;

   // Hash output keeps only the 64-bit squeeze in the upper half.
   assign ob_load      = (state == ST_TXT_RUN) && run_cnt_q && !err_hit;
   assign ob_load_data = (op_q == OP_HASH) ? {core_data_out[127:64], 64'b0} : core_data_out;

   ascon_seq_out_buf u_out_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ob_load),
      .flush     (err_hit),
      .load_data (ob_load_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept && (cmd_op != OP_ILLEGAL)) state_nxt = ST_INIT;
         end
         ST_INIT: begin
            if ((ad_n_q != '0) && (op_q != OP_HASH)) state_nxt = ST_AD_WAIT;
            else if (txt_n_q != '0)                  state_nxt = ST_TXT_WAIT;
            else if (op_q == OP_HASH)                state_nxt = ST_DONE;
            else                                     state_nxt = ST_FINAL;
         end
         ST_AD_WAIT: begin
            if (in_hs) state_nxt = ST_AD_RUN;
         end
         ST_AD_RUN: begin
            if (run_cnt_q) begin
               if (!last_blk)              state_nxt = ST_AD_WAIT;
               else if (txt_n_q != '0)     state_nxt = ST_TXT_WAIT;
               else                        state_nxt = ST_FINAL;
            end
         end
         ST_TXT_WAIT: begin
            if (in_hs) state_nxt = ST_TXT_RUN;
         end
         ST_TXT_RUN: begin
            if (run_cnt_q) begin
               if (!last_blk)              state_nxt = ST_TXT_WAIT;
               else if (op_q == OP_HASH)   state_nxt = ST_DONE;
               else                        state_nxt = ST_FINAL;
            end
         end
         ST_FINAL: state_nxt = ST_DONE;
         ST_DONE: begin
            if (!out_valid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (err_hit) state_nxt = ST_DONE;
   end

   // Enables are decoded from the next state so they are registered and one-hot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready     <= 1'b0;
         core_en_init  <= 1'b0;
         core_en_ad    <= 1'b0;
         core_en_txt   <= 1'b0;
         core_en_hash  <= 1'b0;
         core_en_final <= 1'b0;
         run_cnt_q     <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         cmd_ready     <= (state_nxt == ST_IDLE);
         core_en_init  <= (state_nxt == ST_INIT);
         core_en_ad    <= (state_nxt == ST_AD_RUN);
         core_en_txt   <= (state_nxt == ST_TXT_RUN) && (op_q != OP_HASH);
         core_en_hash  <= (state_nxt == ST_TXT_RUN) && (op_q == OP_HASH);
         core_en_final <= (state_nxt == ST_FINAL);
         run_cnt_q     <= ((state == ST_AD_RUN) || (state == ST_TXT_RUN)) && !run_cnt_q && !err_hit;
         illegal_q     <= accept && (cmd_op == OP_ILLEGAL);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q               <= OP_ENC;
         core_sel_type      <= '0;
         core_mode_dec      <= 1'b0;
         ad_n_q             <= '0;
         txt_n_q            <= '0;
         idx_q              <= '0;
         err_out            <= 1'b0;
         tag_out            <= '0;
         core_data_in       <= '0;
         core_data_length   <= '0;
         core_data_position <= '0;
      end else begin
         if (accept) begin
            op_q          <= seq_op_e'(cmd_op);
            core_sel_type <= cmd_sel_type;
            core_mode_dec <= (cmd_op == OP_DEC);
            ad_n_q        <= cmd_ad_blocks;
            txt_n_q       <= cmd_txt_blocks;
            idx_q         <= '0;
            err_out       <= (cmd_op == OP_ILLEGAL);
            tag_out       <= '0;
         end
         if (err_hit) err_out <= 1'b1;
         if (in_hs) begin
            core_data_in       <= in_data;
            idx_q              <= idx_q + LEN_ONE;
            core_data_position <= idx_q + LEN_ONE;
            core_data_length   <= (state == ST_AD_WAIT) ? ad_n_q : txt_n_q;
         end else if (run_last && last_blk) begin
            idx_q <= '0;
         end
         if ((state == ST_FINAL) && !core_err) tag_out <= core_tag;
      end
   end

`ifdef ASCON_SEQ_TAG_CHECK_EN
   logic [127:0] exp_tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_tag_q <= '0;
         tag_fail  <= 1'b0;
      end else if (accept) begin
         exp_tag_q <= exp_tag;
         tag_fail  <= 1'b0;
      end else if ((state == ST_FINAL) && (op_q == OP_DEC) && (core_tag != exp_tag_q)) begin
         tag_fail  <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/ascon_core_seq.md
Name: ascon_core_seq

Overview:
- Command-level sequencer for the single-permutation Ascon core.
- Accepts one operation (AEAD encrypt, AEAD decrypt or hash) per command and streams 128-bit blocks through valid/ready handshakes.
- Drives the core's one-hot phase enables (init, AD, text, hash, final), block length/position and block data; captures output blocks and the tag.
- Sits between the bus-side register/DMA front end and the core; key and nonce pass to the core directly.

Parameters:
LEN_W, 32, width of block counters and of the core length/position buses

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  operation: OP_ENC=0, OP_DEC=1, OP_HASH=2; 3 is illegal
cmd_sel_type  in  2  variant passed to core_sel_type
cmd_ad_blocks  in  LEN_W  number of AD blocks, 0 allowed
cmd_txt_blocks  in  LEN_W  number of text/message blocks, 0 allowed
in_valid / in_ready  in/out  1  input block handshake
in_data  in  128  AD block, then text block
out_valid / out_ready  out/in  1  output block handshake
out_data  out  128  ciphertext/plaintext block, or {hash64, 64'b0}
done  out  1  one-cycle pulse at end of operation
tag_out  out  128  tag captured at finalisation; held until next command
err_out  out  1  sticky error; cleared on next cmd accept
core_en_init / core_en_ad / core_en_txt / core_en_hash / core_en_final  out  1 each  phase enables, at most one high
core_sel_type  out  2  registered copy of cmd_sel_type
core_mode_dec  out  1  1 for OP_DEC
core_data_length / core_data_position  out  LEN_W each  block count and 1-based block index of the current phase
core_data_in  out  128  registered input block
core_data_out  in  128  core block result
core_tag  in  128  core tag
core_err  in  1  core error flag

Behaviour:
- Reset: all outputs 0; state IDLE; cmd_ready goes to 1 on the first cycle after reset release.
- States: IDLE, INIT, AD_WAIT, AD_RUN, TXT_WAIT, TXT_RUN, FINAL, DONE.
- IDLE: on cmd_valid && cmd_ready, latch all cmd_* fields, clear err_out, go to INIT.
  - cmd_op==3: set err_out, pulse done next cycle, stay in IDLE.
- INIT: core_en_init for exactly 1 cycle. Next state:
  - AD_WAIT if ad_blocks>0 and op!=HASH;
  - else TXT_WAIT if txt_blocks>0;
  - else FINAL (AEAD) or DONE (hash).
- *_WAIT: in_ready=1 unless out_valid && !out_ready (AEAD/hash text only).
  - On in handshake: register in_data into core_data_in, set position=idx (1..N), length=N, go to *_RUN.
- *_RUN: phase enable (ad, txt, or hash for OP_HASH) held exactly 2 cycles; core updates state on the 2nd cycle.
  - Text/hash phases: on the 2nd cycle, capture core_data_out into out_data and set out_valid.
  - out_valid holds until out_ready; out_data is stable while out_valid.
  - After 2 cycles: idx==N -> next phase (AD -> TXT_WAIT, or FINAL if txt=0; TXT -> FINAL for AEAD, DONE for hash); else back to *_WAIT.
- FINAL: core_en_final 1 cycle; capture core_tag into tag_out; go to DONE.
- DONE: wait until out_valid==0, then pulse done for 1 cycle and return to IDLE.
- Error: core_err sampled in any cycle a core enable is high. If set: set err_out, drop all enables, discard pending out_valid, go to DONE.
- Enables are registered and never overlap; core_data_in/length/position are stable for the whole RUN.
- Per-block latency: in handshake to out_valid = 3 cycles.
- rst_n assertion mid-operation: immediate return to reset values; no done pulse.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Optional Feature:
ASCON_SEQ_TAG_CHECK_EN
- With: extra input exp_tag[127:0] latched at cmd accept, plus output tag_fail. For OP_DEC, tag_fail is set in FINAL when core_tag!=exp_tag; it is cleared on the next cmd accept.
- Without: no exp_tag port; tag_fail is absent.

Decomposition:
- Package ascon_seq_pkg: OP_ENC/OP_DEC/OP_HASH/OP_ILLEGAL codes, FSM state encoding, LEN_W default.
- One sub-module ascon_seq_out_buf: single-entry 128-bit output holding register with valid/ready, instanced once.

Test Plan:
- OP_ENC, ad=2, txt=3, out_ready=1, inputs always valid -> enable sequence init x1, ad 2+2, txt 2+2+2, final x1. Positions 1,2 / 1,2,3; exactly 3 out beats; done 1 cycle after FINAL; tag_out == core_tag.
- OP_DEC, ad=0, txt=1 -> no core_en_ad; core_mode_dec=1; 1 out beat; done pulses.
- OP_HASH, txt=4 -> core_en_hash 4x2 cycles; no final; 4 out beats with out_data[63:0]=0.
- out_ready=0 for 10 cycles after first text beat -> in_ready=0 and out_data stable throughout; continues correctly after release.
- core_err forced high during the 2nd AD block -> enables drop next cycle; err_out=1; done pulses; no out beats; next cmd clears err_out.
- cmd_op=3 -> err_out=1; done pulse; no enables. rst_n low during TXT_RUN -> all outputs 0 next cycle.
